// File: rtl/wb_port_master.sv
// Purpose : drives one dual_port_ram Wishbone port from a cmd stream and returns in-order responses.
// Latency : cmd accept -> stb 1 cycle; stb issue -> ack -> rsp_valid_o two cycles after stb at the earliest.
// Backpress: cmd_ready_o drops when held+in-flight+buffered work would exceed RSP_DEPTH; stb held through stall.
// Optional: define WB_TIMEOUT_EN to retire unacknowledged transactions as error responses after TO_CYCLES.
module wb_port_master #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int RSP_DEPTH = 4,
   parameter int TO_CYCLES = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_W-1:0]     cmd_addr_i,
   input  logic [DATA_W/8-1:0]   cmd_sel_i,
   input  logic [DATA_W-1:0]     cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic                  rsp_we_o,
   output logic [DATA_W-1:0]     rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  wb_stb_o,
   output logic                  wb_we_o,
   output logic [ADDR_W-1:0]     wb_addr_o,
   output logic [DATA_W/8-1:0]   wb_sel_o,
   output logic [DATA_W-1:0]     wb_data_o,
   input  logic                  wb_stall_i,
   input  logic                  wb_ack_i,
   input  logic [DATA_W-1:0]     wb_data_i,
   output logic                  busy_o,
   output logic                  proto_err_o
);

   localparam int SEL_W = DATA_W / 8;
   localparam int PW    = $clog2(RSP_DEPTH);
   localparam int CW    = PW + 1;

   // Pointer arithmetic relies on natural wrap, so the depth must be a power of two.
   if (RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : gBadDepth
      $error("wb_port_master: RSP_DEPTH must be a power of two >= 2");
   end
   if (TO_CYCLES < 1) begin : gBadTimeout
      $error("wb_port_master: TO_CYCLES must be >= 1");
   end

   typedef enum logic {IDLE, REQ} state_t;

   state_t              state;
   logic [CW-1:0]       outCnt;
   logic [CW-1:0]       outNext;
   logic [RSP_DEPTH-1:0] weQ;
   logic [RSP_DEPTH-1:0] weQNext;

   logic [DATA_W-1:0]   fifoData [RSP_DEPTH];
   logic [RSP_DEPTH-1:0] fifoWe;
   logic [PW-1:0]       wrPtr;
   logic [PW-1:0]       rdPtr;
   logic [CW-1:0]       fifoCnt;
   logic [CW-1:0]       pushN;

   logic                issue;
   logic                ackHit;
   logic                cmdAcc;
   logic                rspPop;
   logic                credit;
   logic [CW:0]         creditSum;
   logic                toFire;
   logic                protoErr;

   assign issue  = wb_stb_o & ~wb_stall_i;
   // An ack with nothing in flight is a slave protocol violation and is not turned into a response.
   assign ackHit = wb_ack_i & (outCnt != '0);

   // The held request counts against the budget so an accepted command always has a FIFO slot waiting.
   assign creditSum   = {1'b0, outCnt} + {1'b0, fifoCnt} + {{CW{1'b0}}, wb_stb_o};
   assign credit      = creditSum < (CW+1)'(RSP_DEPTH);
   assign cmd_ready_o = credit & ((state == IDLE) | issue);
   assign cmdAcc      = cmd_valid_i & cmd_ready_o;

   assign rsp_valid_o = (fifoCnt != '0);
   assign rsp_we_o    = fifoWe[rdPtr];
   assign rsp_rdata_o = fifoData[rdPtr];
   assign rspPop      = rsp_valid_o & rsp_ready_i;

   assign busy_o      = (state == REQ) | (outCnt != '0) | (fifoCnt != '0);
   assign proto_err_o = protoErr;

   // Request FSM: registers the command onto the bus and holds it until the slave takes it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         wb_stb_o  <= 1'b0;
         wb_we_o   <= 1'b0;
         wb_addr_o <= '0;
         wb_sel_o  <= '0;
         wb_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmdAcc) begin
                  state     <= REQ;
                  wb_stb_o  <= 1'b1;
                  wb_we_o   <= cmd_we_i;
                  wb_addr_o <= cmd_addr_i;
                  wb_sel_o  <= cmd_sel_i;
                  wb_data_o <= cmd_wdata_i;
               end
            end
            REQ: begin
               if (!wb_stall_i) begin
                  if (cmdAcc) begin
                     wb_we_o   <= cmd_we_i;
                     wb_addr_o <= cmd_addr_i;
                     wb_sel_o  <= cmd_sel_i;
                     wb_data_o <= cmd_wdata_i;
                  end else begin
                     state    <= IDLE;
                     wb_stb_o <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               wb_stb_o <= 1'b0;
            end
         endcase
      end
   end

   // Next in-flight count and write-flag queue: ack retires the oldest (bit 0), issue appends at the tail.
   always_comb begin
      weQNext = weQ;
      outNext = outCnt;
      if (ackHit) begin
         weQNext = weQ >> 1;
         outNext = outCnt - CW'(1);
      end
      if (toFire) begin
         weQNext = '0;
         outNext = '0;
      end
      if (issue) begin
         weQNext[outNext[PW-1:0]] = wb_we_o;
         outNext = outNext + CW'(1);
      end
   end

   // Response entries written this cycle: one per ack, or every in-flight txn on a timeout.
   always_comb begin
      pushN = '0;
      if (ackHit) begin
         pushN = CW'(1);
      end else if (toFire) begin
         pushN = outCnt;
      end
   end

   // In-flight tracking, FIFO pointers and the sticky protocol-error flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         outCnt   <= '0;
         weQ      <= '0;
         wrPtr    <= '0;
         rdPtr    <= '0;
         fifoCnt  <= '0;
         protoErr <= 1'b0;
      end else begin
         outCnt  <= outNext;
         weQ     <= weQNext;
         wrPtr   <= wrPtr + pushN[PW-1:0];
         rdPtr   <= rdPtr + {{(PW-1){1'b0}}, rspPop};
         fifoCnt <= fifoCnt + pushN - {{PW{1'b0}}, rspPop};
         if (wb_ack_i && outCnt == '0) begin
            protoErr <= 1'b1;
         end
      end
   end

   // Response storage; write completions carry zero data so stale bus data never leaks out.
   always_ff @(posedge clk_i) begin
      if (ackHit) begin
         fifoData[wrPtr] <= weQ[0] ? '0 : wb_data_i;
         fifoWe[wrPtr]   <= weQ[0];
      end else if (toFire) begin
         for (int k = 0; k < RSP_DEPTH; k++) begin
            if (CW'(k) < outCnt) begin
               fifoData[wrPtr + PW'(k)] <= '0;
               fifoWe[wrPtr + PW'(k)]   <= weQ[k];
            end
         end
      end
   end

`ifdef WB_TIMEOUT_EN
   localparam int TW = $clog2(TO_CYCLES + 1);

   logic [TW-1:0]        toCnt;
   logic [RSP_DEPTH-1:0] fifoErr;

   assign toFire    = (outCnt != '0) & ~ackHit & (toCnt == TW'(TO_CYCLES - 1));
   assign rsp_err_o = fifoErr[rdPtr];

   // Ack watchdog: restarts on every ack and idles while nothing is in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i || outCnt == '0 || ackHit || toFire) begin
         toCnt <= '0;
      end else begin
         toCnt <= toCnt + TW'(1);
      end
   end

   // Error flag per FIFO entry, written alongside the data entry.
   always_ff @(posedge clk_i) begin
      if (ackHit) begin
         fifoErr[wrPtr] <= 1'b0;
      end else if (toFire) begin
         for (int k = 0; k < RSP_DEPTH; k++) begin
            if (CW'(k) < outCnt) begin
               fifoErr[wrPtr + PW'(k)] <= 1'b1;
            end
         end
      end
   end
`else
   assign toFire    = 1'b0;
   assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_master.sv
// Bench for wb_port_master: a behavioural single-port RAM slave with bench-controlled stall
// stands in for dual_port_ram; port-B collisions are modelled by stalling A and writing RAM directly.
module tb_wb_port_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmdValid, cmdReady, cmdWe;
   logic [8:0]  cmdAddr;
   logic [3:0]  cmdSel;
   logic [31:0] cmdWdata;
   logic        rspValid, rspReady, rspWe, rspErr;
   logic [31:0] rspRdata;
   logic        wbStb, wbWe, wbStall, wbAck;
   logic [8:0]  wbAddr;
   logic [3:0]  wbSel;
   logic [31:0] wbDataOut, wbDataIn;
   logic        busy, protoErr;

   logic        stallReq, ackBlock, strayAck, ackQ;
   logic [31:0] rdQ;
   logic [31:0] ram [512];
   int          issueCnt = 0;
   int          acceptCnt = 0;
   logic [33:0] rspQ [$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_port_master dut (
      .clk_i(clk), .rst_i(rst),
      .cmd_valid_i(cmdValid), .cmd_ready_o(cmdReady), .cmd_we_i(cmdWe),
      .cmd_addr_i(cmdAddr), .cmd_sel_i(cmdSel), .cmd_wdata_i(cmdWdata),
      .rsp_valid_o(rspValid), .rsp_ready_i(rspReady), .rsp_we_o(rspWe),
      .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr),
      .wb_stb_o(wbStb), .wb_we_o(wbWe), .wb_addr_o(wbAddr), .wb_sel_o(wbSel),
      .wb_data_o(wbDataOut), .wb_stall_i(wbStall), .wb_ack_i(wbAck), .wb_data_i(wbDataIn),
      .busy_o(busy), .proto_err_o(protoErr)
   );

   assign wbStall  = stallReq;
   assign wbAck    = ackQ | strayAck;
   assign wbDataIn = rdQ;

   // Slave: accepts when not stalled, acks one cycle later (ack may be suppressed to model a dead slave).
   always @(posedge clk) begin
      ackQ <= 1'b0;
      if (wbStb && !wbStall) begin
         issueCnt <= issueCnt + 1;
         if (wbWe) begin
            for (int b = 0; b < 4; b++) if (wbSel[b]) ram[wbAddr][8*b +: 8] = wbDataOut[8*b +: 8];
         end else begin
            rdQ <= ram[wbAddr];
         end
         ackQ <= !ackBlock;
      end
   end

   // Handshake monitors.
   always @(posedge clk) begin
      if (!rst && rspValid && rspReady) rspQ.push_back({rspErr, rspWe, rspRdata});
      if (!rst && cmdValid && cmdReady) acceptCnt <= acceptCnt + 1;
   end

   task automatic sendCmd(input logic we, input logic [8:0] addr, input logic [3:0] sel, input logic [31:0] wdata);
      bit done;
      done = 1'b0;
      cmdValid = 1'b1; cmdWe = we; cmdAddr = addr; cmdSel = sel; cmdWdata = wdata;
      for (int i = 0; i < 50 && !done; i++) begin
         #1; done = cmdReady;
         @(negedge clk);
      end
      cmdValid = 1'b0;
      if (!done) begin checks++; errors++; $display("FAIL cmd_accept_bound: ready never seen for addr %h", addr); end
   endtask

   task automatic doReset;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      @(negedge clk); @(negedge clk);
      checks++; if (wbStb !== 1'b0)    begin errors++; $display("FAIL rst_stb: got %b want 0", wbStb); end
      checks++; if (wbWe !== 1'b0)     begin errors++; $display("FAIL rst_we: got %b want 0", wbWe); end
      checks++; if (wbAddr !== 9'h0)   begin errors++; $display("FAIL rst_addr: got %h want 0", wbAddr); end
      checks++; if (wbSel !== 4'h0)    begin errors++; $display("FAIL rst_sel: got %h want 0", wbSel); end
      checks++; if (wbDataOut !== 32'h0) begin errors++; $display("FAIL rst_data: got %h want 0", wbDataOut); end
      checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", rspValid); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (protoErr !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %b want 0", protoErr); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_write_read;
      cmdValid = 1'b1; cmdWe = 1'b1; cmdAddr = 9'h000; cmdSel = 4'hF; cmdWdata = 32'h0123_4567;
      #1;
      checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL wr_ready_idle: got %b want 1", cmdReady); end
      @(negedge clk);
      checks++; if (wbStb !== 1'b1)    begin errors++; $display("FAIL wr_stb: got %b want 1", wbStb); end
      checks++; if (wbWe !== 1'b1)     begin errors++; $display("FAIL wr_we: got %b want 1", wbWe); end
      checks++; if (wbDataOut !== 32'h0123_4567) begin errors++; $display("FAIL wr_data: got %h want 01234567", wbDataOut); end
      cmdWe = 1'b0; cmdWdata = 32'h0;
      #1;
      checks++; if (cmdReady !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", cmdReady); end
      @(negedge clk);
      cmdValid = 1'b0;
      checks++; if (wbStb !== 1'b1 || wbWe !== 1'b0 || wbAddr !== 9'h0) begin errors++; $display("FAIL rd_stb: got stb=%b we=%b addr=%h want 1 0 000", wbStb, wbWe, wbAddr); end
      checks++; if (rspValid !== 1'b0) begin errors++; $display("FAIL rsp_early: got %b want 0", rspValid); end
      @(negedge clk);
      checks++; if (wbStb !== 1'b0)    begin errors++; $display("FAIL rd_stb_drop: got %b want 0", wbStb); end
      checks++; if (rspValid !== 1'b1 || rspWe !== 1'b1 || rspRdata !== 32'h0) begin errors++; $display("FAIL wr_rsp: got v=%b we=%b d=%h want 1 1 0", rspValid, rspWe, rspRdata); end
      @(negedge clk);
      checks++; if (rspValid !== 1'b1 || rspWe !== 1'b0 || rspRdata !== 32'h0123_4567) begin errors++; $display("FAIL rd_rsp: got v=%b we=%b d=%h want 1 0 01234567", rspValid, rspWe, rspRdata); end
      checks++; if (rspErr !== 1'b0)   begin errors++; $display("FAIL rd_rsp_err: got %b want 0", rspErr); end
      @(negedge clk);
      checks++; if (rspValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL wr_rd_idle: got v=%b busy=%b want 0 0", rspValid, busy); end
   endtask

   task automatic test_stall_hold;
      int base;
      ram[0] = 32'h0; ram[1] = 32'h0;
      rspQ.delete();
      base = issueCnt;
      cmdValid = 1'b1; cmdWe = 1'b1; cmdAddr = 9'h000; cmdSel = 4'hF; cmdWdata = 32'h0123_4567;
      @(negedge clk);
      cmdValid = 1'b0;
      stallReq = 1'b1;
      ram[1] = 32'h89AB_CDEF;
      #1;
      checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", cmdReady); end
      @(negedge clk);
      checks++; if (wbStb !== 1'b1 || wbAddr !== 9'h000 || wbDataOut !== 32'h0123_4567) begin errors++; $display("FAIL stall_hold: got stb=%b addr=%h d=%h want 1 000 01234567", wbStb, wbAddr, wbDataOut); end
      @(negedge clk);
      checks++; if (wbStb !== 1'b1 || wbWe !== 1'b1 || wbSel !== 4'hF) begin errors++; $display("FAIL stall_hold2: got stb=%b we=%b sel=%h want 1 1 f", wbStb, wbWe, wbSel); end
      stallReq = 1'b0;
      @(negedge clk);
      checks++; if (wbStb !== 1'b0)    begin errors++; $display("FAIL stall_release: got %b want 0", wbStb); end
      @(negedge clk); @(negedge clk); @(negedge clk);
      checks++; if (issueCnt - base !== 1) begin errors++; $display("FAIL stall_issues: got %0d want 1", issueCnt - base); end
      checks++; if (ram[0] !== 32'h0123_4567 || ram[1] !== 32'h89AB_CDEF) begin errors++; $display("FAIL stall_ram: got %h %h want 01234567 89abcdef", ram[0], ram[1]); end
      checks++; if (rspQ.size() !== 1) begin errors++; $display("FAIL stall_rsp_count: got %0d want 1", rspQ.size()); end
      else begin
         checks++; if (rspQ[0] !== {2'b01, 32'h0}) begin errors++; $display("FAIL stall_rsp: got %h want 100000000", rspQ[0]); end
      end
   endtask

   task automatic test_back_to_back;
      int  sent, acc0, base;
      bit  acc;
      logic [31:0] exp;
      for (int i = 0; i < 8; i++) ram[9'h100 + i] = 32'hA5A5_0000 + 32'h111 * 32'(i);
      rspQ.delete();
      rspReady = 1'b0;
      acc0 = acceptCnt; base = issueCnt;
      sent = 0;
      cmdValid = 1'b1; cmdWe = 1'b0; cmdSel = 4'hF; cmdWdata = 32'h0; cmdAddr = 9'h100;
      for (int c = 0; c < 20; c++) begin
         #1; acc = cmdValid && cmdReady;
         @(negedge clk);
         if (acc) sent++;
         cmdAddr = 9'h100 + 9'(sent);
      end
      #1;
      checks++; if (sent !== 4 || acceptCnt - acc0 !== 4) begin errors++; $display("FAIL credit_accepts: got %0d/%0d want 4", sent, acceptCnt - acc0); end
      checks++; if (cmdReady !== 1'b0) begin errors++; $display("FAIL credit_ready: got %b want 0", cmdReady); end
      checks++; if (rspValid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL credit_hold: got v=%b busy=%b want 1 1", rspValid, busy); end
      rspReady = 1'b1;
      for (int c = 0; c < 80 && !(sent == 8 && rspQ.size() == 8); c++) begin
         #1; acc = cmdValid && cmdReady;
         @(negedge clk);
         if (acc) sent++;
         cmdAddr = 9'h100 + 9'(sent);
         if (sent == 8) cmdValid = 1'b0;
      end
      cmdValid = 1'b0;
      checks++; if (rspQ.size() !== 8 || issueCnt - base !== 8) begin errors++; $display("FAIL b2b_count: got rsp=%0d issues=%0d want 8 8", rspQ.size(), issueCnt - base); end
      for (int i = 0; i < 8 && i < rspQ.size(); i++) begin
         exp = 32'hA5A5_0000 + 32'h111 * 32'(i);
         checks++; if (rspQ[i] !== {2'b00, exp}) begin errors++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rspQ[i], {2'b00, exp}); end
      end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_reset_inflight;
      ackBlock = 1'b1;
      cmdValid = 1'b1; cmdWe = 1'b0; cmdSel = 4'hF; cmdAddr = 9'h010;
      @(negedge clk);
      cmdAddr = 9'h011;
      @(negedge clk);
      cmdValid = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b1 || wbStb !== 1'b0) begin errors++; $display("FAIL inflight_busy: got busy=%b stb=%b want 1 0", busy, wbStb); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (wbStb !== 1'b0 || busy !== 1'b0 || rspValid !== 1'b0) begin errors++; $display("FAIL midrst: got stb=%b busy=%b v=%b want 0 0 0", wbStb, busy, rspValid); end
      rst = 1'b0; ackBlock = 1'b0;
      rspQ.delete();
      @(negedge clk);
      checks++; if (protoErr !== 1'b0) begin errors++; $display("FAIL pre_stray: got %b want 0", protoErr); end
      strayAck = 1'b1;
      @(negedge clk);
      strayAck = 1'b0;
      checks++; if (protoErr !== 1'b1) begin errors++; $display("FAIL stray_proto: got %b want 1", protoErr); end
      @(negedge clk);
      checks++; if (rspValid !== 1'b0 || rspQ.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL stray_rsp: got v=%b n=%0d busy=%b want 0 0 0", rspValid, rspQ.size(), busy); end
      @(negedge clk);
      checks++; if (protoErr !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b want 1", protoErr); end
      doReset();
   endtask

   task automatic test_byte_sel;
      ram[9'h1FF] = 32'h1122_3344;
      rspQ.delete();
      sendCmd(1'b1, 9'h1FF, 4'b0011, 32'hCAFE_BABE);
      sendCmd(1'b0, 9'h1FF, 4'hF, 32'h0);
      for (int i = 0; i < 6; i++) @(negedge clk);
      checks++; if (rspQ.size() !== 2) begin errors++; $display("FAIL sel_count: got %0d want 2", rspQ.size()); end
      else begin
         checks++; if (rspQ[0] !== {2'b01, 32'h0}) begin errors++; $display("FAIL sel_wr_rsp: got %h want 100000000", rspQ[0]); end
         checks++; if (rspQ[1] !== {2'b00, 32'h1122_BABE}) begin errors++; $display("FAIL sel_rd_rsp: got %h want 01122babe", rspQ[1]); end
      end
      checks++; if (ram[9'h1FF] !== 32'h1122_BABE) begin errors++; $display("FAIL sel_ram: got %h want 1122babe", ram[9'h1FF]); end
   endtask

`ifdef WB_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      doReset();
      ackBlock = 1'b1; rspReady = 1'b0;
      rspQ.delete();
      sendCmd(1'b0, 9'h020, 4'hF, 32'h0);
      n = 0;
      for (int i = 1; i <= 100 && n == 0; i++) begin
         @(negedge clk);
         if (rspValid) n = i;
      end
      checks++; if (n < 62 || n > 68) begin errors++; $display("FAIL to_latency: got %0d cycles want about 64", n); end
      checks++; if (rspErr !== 1'b1 || rspRdata !== 32'h0 || rspWe !== 1'b0) begin errors++; $display("FAIL to_rsp: got err=%b d=%h we=%b want 1 0 0", rspErr, rspRdata, rspWe); end
      rspReady = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || rspValid !== 1'b0) begin errors++; $display("FAIL to_busy: got busy=%b v=%b want 0 0", busy, rspValid); end
      ackBlock = 1'b0;
      strayAck = 1'b1;
      @(negedge clk);
      strayAck = 1'b0;
      checks++; if (protoErr !== 1'b1) begin errors++; $display("FAIL to_late_ack: got %b want 1", protoErr); end
      doReset();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 512; i++) ram[i] = 32'h0;
      rst = 1'b1; cmdValid = 1'b0; cmdWe = 1'b0; cmdAddr = 9'h0; cmdSel = 4'h0; cmdWdata = 32'h0;
      rspReady = 1'b1; stallReq = 1'b0; ackBlock = 1'b0; strayAck = 1'b0;
      ackQ = 1'b0; rdQ = 32'h0;
      test_reset();
      test_write_read();
      test_stall_hold();
      test_back_to_back();
      test_reset_inflight();
      test_byte_sel();
`ifdef WB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
